// File: rtl/pipeline_hazard_controller_pkg.sv
// pipeline_hazard_controller_pkg: shared hazard FSM state and register-index constants
package pipeline_hazard_controller_pkg;
  typedef enum logic {HZ_RUN, HZ_MEM_WAIT} hz_state_e;
  localparam logic [4:0] REG_X0 = 5'd0;
  localparam int WAIT_W = 16;
endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// pipeline_hazard_controller_if: hazard events from the pipeline and the stage enable/clear controls back
interface pipeline_hazard_controller_if;
  logic [4:0] id_rs1_idx;
  logic [4:0] id_rs2_idx;
  logic       id_uses_rs1;
  logic       id_uses_rs2;
  logic       ex_is_load;
  logic [4:0] ex_wr_reg_idx;
  logic       ex_branch_taken;
  logic       mem_access;
  logic       dmem_ready;
  logic       imem_ready;
  logic       pc_enable;
  logic       if_id_enable;
  logic       if_id_clear;
  logic       id_ex_enable;
  logic       id_ex_clear;
  logic       ex_mem_enable;
  logic       ex_mem_clear;
  logic       mem_wb_enable;
  logic       mem_wb_clear;
  modport master (
    output id_rs1_idx, id_rs2_idx, id_uses_rs1, id_uses_rs2, ex_is_load, ex_wr_reg_idx,
           ex_branch_taken, mem_access, dmem_ready, imem_ready,
    input  pc_enable, if_id_enable, if_id_clear, id_ex_enable, id_ex_clear,
           ex_mem_enable, ex_mem_clear, mem_wb_enable, mem_wb_clear
  );
  modport slave (
    input  id_rs1_idx, id_rs2_idx, id_uses_rs1, id_uses_rs2, ex_is_load, ex_wr_reg_idx,
           ex_branch_taken, mem_access, dmem_ready, imem_ready,
    output pc_enable, if_id_enable, if_id_clear, id_ex_enable, id_ex_clear,
           ex_mem_enable, ex_mem_clear, mem_wb_enable, mem_wb_clear
  );
endinterface

// File: rtl/hazard_perf_counters.sv
// hazard_perf_counters: stall/flush performance counters and the data-memory wait watchdog
module hazard_perf_counters
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  input  logic             in_wait,
  input  logic             stay_wait,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);
  localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(MEM_TIMEOUT);
  logic [CNT_W-1:0]  stall_q, stall_d, flush_q, flush_d;
  logic [WAIT_W-1:0] wait_q, wait_d, wait_inc;
  logic              err_q, err_d;
  always_comb begin
    wait_inc = &wait_q ? wait_q : wait_q + WAIT_W'(1);
    wait_d   = in_wait & stay_wait ? wait_inc : '0;
    err_d    = err_q | (in_wait & (wait_inc >= LIMIT));
    stall_d  = stall_q + CNT_W'(stall);
    flush_d  = flush_q + CNT_W'(flush);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end
  assign mem_timeout_err = err_q;
  assign stall_cycles    = stall_q;
  assign flush_count     = flush_q;
endmodule

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: stall/flush sequencer driving pipeline register and PC controls
module pipeline_hazard_controller
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  pipeline_hazard_controller_if.slave  hz,
  output logic                         mem_timeout_err,
  output logic [CNT_W-1:0]             stall_cycles,
  output logic [CNT_W-1:0]             flush_count
);
  hz_state_e state_q, state_d;
  logic mem_stall, branch, load_use, fetch_wait, rs1_hit, rs2_hit, run;
  always_comb begin
    run        = rst_n;
    mem_stall  = hz.mem_access & !hz.dmem_ready;
    branch     = !mem_stall & hz.ex_branch_taken;
    rs1_hit    = hz.id_uses_rs1 & (hz.id_rs1_idx == hz.ex_wr_reg_idx);
    rs2_hit    = hz.id_uses_rs2 & (hz.id_rs2_idx == hz.ex_wr_reg_idx);
    load_use   = !mem_stall & !hz.ex_branch_taken & hz.ex_is_load &
                 (hz.ex_wr_reg_idx != REG_X0) & (rs1_hit | rs2_hit);
    fetch_wait = !mem_stall & !hz.ex_branch_taken & !load_use & !hz.imem_ready;
    state_d    = state_q == HZ_RUN ? (mem_stall ? HZ_MEM_WAIT : HZ_RUN)
                                   : (hz.dmem_ready ? HZ_RUN : HZ_MEM_WAIT);
    // a memory stall freezes everything up to MEM and bubbles WB so nothing writes back twice
    hz.pc_enable     = run & !mem_stall & !load_use & !fetch_wait;
    hz.if_id_enable  = run & !mem_stall & !load_use;
    hz.if_id_clear   = !run | branch | fetch_wait;
    hz.id_ex_enable  = run & !mem_stall;
    hz.id_ex_clear   = !run | branch | load_use;
    hz.ex_mem_enable = run & !mem_stall;
    hz.ex_mem_clear  = !run;
    hz.mem_wb_enable = run;
    hz.mem_wb_clear  = !run | mem_stall;
  end
  always_ff @(posedge clk) state_q <= !rst_n ? HZ_RUN : state_d;
  hazard_perf_counters #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) u_perf (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (!hz.pc_enable),
    .flush          (branch),
    .in_wait        (state_q == HZ_MEM_WAIT),
    .stay_wait      (state_d == HZ_MEM_WAIT),
    .mem_timeout_err(mem_timeout_err),
    .stall_cycles   (stall_cycles),
    .flush_count    (flush_count)
  );
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb_pipeline_hazard_controller: directed and randomized checks against a priority-rule reference model
module tb_pipeline_hazard_controller;
  localparam int TO = 3;
  localparam int CW = 32;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic err;
  logic [CW-1:0] stall_cycles, flush_count;
  int n_chk = 0;
  int n_pass = 0;
  string phase = "init";
  bit mvalid = 0;
  bit m_wait = 0;
  bit m_err = 0;
  int m_waited = 0;
  logic [CW-1:0] m_stall = '0;
  logic [CW-1:0] m_flush = '0;
  pipeline_hazard_controller_if hz();
  pipeline_hazard_controller #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .hz(hz), .mem_timeout_err(err),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );
  always #5 clk = ~clk;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // {pc, if_id en/clr, id_ex en/clr, ex_mem en/clr, mem_wb en/clr}
  function automatic logic [8:0] exp_ctl();
    bit lu;
    if (!rst_n) return 9'b0_01_01_01_01;
    if (hz.mem_access && !hz.dmem_ready) return 9'b0_00_00_00_11;
    if (hz.ex_branch_taken) return 9'b1_11_11_10_10;
    lu = hz.ex_is_load && hz.ex_wr_reg_idx != 0 &&
         ((hz.id_uses_rs1 && hz.id_rs1_idx == hz.ex_wr_reg_idx) ||
          (hz.id_uses_rs2 && hz.id_rs2_idx == hz.ex_wr_reg_idx));
    if (lu) return 9'b0_00_11_10_10;
    if (!hz.imem_ready) return 9'b0_11_10_10_10;
    return 9'b1_10_10_10_10;
  endfunction

  task automatic model_tick(logic [8:0] ctl);
    if (!rst_n) begin
      mvalid = 1; m_wait = 0; m_waited = 0; m_err = 0; m_stall = '0; m_flush = '0;
    end else begin
      if (!ctl[8]) m_stall = m_stall + 1;
      if (hz.ex_branch_taken && !(hz.mem_access && !hz.dmem_ready)) m_flush = m_flush + 1;
      if (m_wait) begin
        m_waited++;
        if (m_waited >= TO) m_err = 1;
        if (hz.dmem_ready) begin m_wait = 0; m_waited = 0; end
      end else if (hz.mem_access && !hz.dmem_ready) m_wait = 1;
    end
  endtask

  task automatic cyc();
    logic [8:0] e;
    @(negedge clk);
    e = exp_ctl();
    check({phase, ".ctl"}, {hz.pc_enable, hz.if_id_enable, hz.if_id_clear, hz.id_ex_enable,
          hz.id_ex_clear, hz.ex_mem_enable, hz.ex_mem_clear, hz.mem_wb_enable, hz.mem_wb_clear}, e);
    if (mvalid) begin
      check({phase, ".stall"}, stall_cycles, m_stall);
      check({phase, ".flush"}, flush_count, m_flush);
      check({phase, ".err"}, err, m_err);
    end
    @(posedge clk);
    model_tick(e);
    #1;
  endtask

  task automatic idle();
    hz.id_rs1_idx = '0; hz.id_rs2_idx = '0; hz.id_uses_rs1 = 0; hz.id_uses_rs2 = 0;
    hz.ex_is_load = 0; hz.ex_wr_reg_idx = '0; hz.ex_branch_taken = 0;
    hz.mem_access = 0; hz.dmem_ready = 0; hz.imem_ready = 1;
  endtask

  task automatic rnd();
    hz.id_rs1_idx = 5'($urandom_range(0, 3));
    hz.id_rs2_idx = 5'($urandom_range(0, 3));
    hz.ex_wr_reg_idx = 5'($urandom_range(0, 3));
    hz.id_uses_rs1 = 1'($urandom_range(0, 1));
    hz.id_uses_rs2 = 1'($urandom_range(0, 1));
    hz.ex_is_load = 1'($urandom_range(0, 1));
    hz.ex_branch_taken = $urandom_range(0, 9) < 2;
    hz.mem_access = $urandom_range(0, 9) < 3;
    hz.dmem_ready = 1'($urandom_range(0, 1));
    hz.imem_ready = $urandom_range(0, 9) < 8;
  endtask

  task automatic do_reset();
    rst_n = 0; idle(); cyc(); rst_n = 1; idle();
  endtask

  task automatic set_load_use(logic [4:0] idx);
    hz.ex_is_load = 1; hz.ex_wr_reg_idx = idx; hz.id_rs2_idx = idx; hz.id_uses_rs2 = 1;
  endtask

  initial begin
    idle();
    phase = "reset";
    rst_n = 0;
    repeat (3) begin rnd(); cyc(); end
    check("reset.stall0", stall_cycles, 0);
    check("reset.flush0", flush_count, 0);
    check("reset.err0", err, 0);
    rst_n = 1; idle();
    phase = "release";
    cyc();
    phase = "loaduse";
    set_load_use(5); cyc();
    idle(); cyc();
    check("loaduse.stall1", stall_cycles, 1);
    set_load_use(0); cyc();
    idle(); cyc();
    check("loaduse.x0", stall_cycles, 1);
    phase = "brlu";
    do_reset();
    set_load_use(5); hz.ex_branch_taken = 1; hz.imem_ready = 0; cyc();
    idle(); cyc();
    check("brlu.flush1", flush_count, 1);
    check("brlu.stall0", stall_cycles, 0);
    phase = "memwait";
    do_reset();
    hz.mem_access = 1; hz.dmem_ready = 0;
    for (int i = 0; i < 4; i++) begin hz.ex_branch_taken = i >= 2; cyc(); end
    check("memwait.noflush", flush_count, 0);
    hz.dmem_ready = 1; hz.ex_branch_taken = 1; cyc();
    idle(); cyc();
    check("memwait.stall4", stall_cycles, 4);
    check("memwait.flush1", flush_count, 1);
    phase = "timeout";
    do_reset();
    hz.mem_access = 1; hz.dmem_ready = 0;
    repeat (3) cyc();
    check("timeout.before", err, 0);
    cyc();
    check("timeout.set", err, 1);
    hz.dmem_ready = 1; cyc();
    idle(); cyc();
    check("timeout.sticky", err, 1);
    do_reset(); cyc();
    check("timeout.cleared", err, 0);
    phase = "fetchwait";
    hz.imem_ready = 0;
    repeat (2) cyc();
    idle(); cyc();
    phase = "random";
    repeat (3000) begin
      rst_n = $urandom_range(0, 99) != 0;
      rnd();
      cyc();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
